// File: rtl/branch_cmp_unit.sv
// rtl/branch_cmp_unit.sv - single-cycle branch condition compare unit with valid/ready result register
//
// Purpose:
//   Evaluates one of eight branch conditions on operands a/b and returns the
//   taken bit, the raw a==b equality and the issue tag one cycle after the
//   issue is accepted. The single result register is a pipeline stage with
//   full throughput: a held result can be consumed and replaced in one cycle.
//
// Optional feature (macro BRCMP_STAT_EN):
//   Adds stat_clr and two saturating 32-bit counters, stat_issued and
//   stat_taken. When the macro is undefined, those ports and counters do not
//   exist.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   in_valid    in   issue request present
//   in_ready    out  unit can accept an issue this cycle (!out_valid || out_ready)
//   in_op       in   compare mode: EQ NE LTZ GEZ GTZ LEZ LT LTU (000..111)
//   in_a        in   first operand (rs)
//   in_b        in   second operand (rt), unused by the zero-compare modes
//   in_tag      in   issue tag
//   flush       in   squash the held result and any issue this cycle
//   out_valid   out  result register holds a valid result
//   out_ready   in   consumer takes the result this cycle
//   out_taken   out  branch condition of the held result
//   out_eq      out  raw a==b of the held result
//   out_tag     out  tag of the held result
//   stat_clr    in   (BRCMP_STAT_EN) synchronous counter clear, wins over increment
//   stat_issued out  (BRCMP_STAT_EN) accepted issue count, saturating
//   stat_taken  out  (BRCMP_STAT_EN) accepted issues whose condition was true, saturating

module branch_cmp_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_eq,
  output logic [TAG_W-1:0] out_tag
`ifdef BRCMP_STAT_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_taken
`endif
);

  // Compare mode encoding.
  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LTZ = 3'b010;
  localparam logic [2:0] OP_GEZ = 3'b011;
  localparam logic [2:0] OP_GTZ = 3'b100;
  localparam logic [2:0] OP_LEZ = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_LTU = 3'b111;

  logic accept;
  logic consume;
  logic a_eq_b;
  logic a_neg;
  logic a_zero;
  logic a_lt_b_s;
  logic a_lt_b_u;
  logic cond;

  // Ready deliberately ignores flush so the upstream handshake never sees a
  // combinational path from the squash signal.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = out_valid && out_ready;

  // Operand relations. The signed compare is done at full WIDTH on signed
  // views of the operands, so there is no subtract-and-overflow wrap.
  assign a_eq_b   = (in_a == in_b);
  assign a_neg    = in_a[WIDTH-1];
  assign a_zero   = (in_a == '0);
  assign a_lt_b_s = ($signed(in_a) < $signed(in_b));
  assign a_lt_b_u = (in_a < in_b);

  always_comb begin
    cond = 1'b0;
    unique case (in_op)
      OP_EQ:   cond = a_eq_b;
      OP_NE:   cond = !a_eq_b;
      OP_LTZ:  cond = a_neg;
      OP_GEZ:  cond = !a_neg;
      OP_GTZ:  cond = !a_neg && !a_zero;
      OP_LEZ:  cond = a_neg || a_zero;
      OP_LT:   cond = a_lt_b_s;
      OP_LTU:  cond = a_lt_b_u;
      default: cond = 1'b0;
    endcase
  end

  // Valid bit: flush dominates, then a new accept, then a plain consume.
  // An accept in the same cycle as a consume keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

  // Payload only moves on an accept, which also keeps it frozen while the
  // consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_taken <= 1'b0;
      out_eq    <= 1'b0;
      out_tag   <= '0;
    end else if (accept) begin
      out_taken <= cond;
      out_eq    <= a_eq_b;
      out_tag   <= in_tag;
    end
  end

`ifdef BRCMP_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_taken  <= '0;
    end else if (stat_clr) begin
      stat_issued <= '0;
      stat_taken  <= '0;
    end else if (accept) begin
      if (stat_issued != 32'hFFFF_FFFF) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if (cond && (stat_taken != 32'hFFFF_FFFF)) begin
        stat_taken <= stat_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_cmp_unit.sv
// tb/tb_branch_cmp_unit.sv - scoreboard bench for branch_cmp_unit

module tb_branch_cmp_unit;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic             out_eq;
  logic [TAG_W-1:0] out_tag;
`ifdef BRCMP_STAT_EN
  logic             stat_clr;
  logic [31:0]      stat_issued;
  logic [31:0]      stat_taken;
`endif

  branch_cmp_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_taken (out_taken),
    .out_eq    (out_eq),
    .out_tag   (out_tag)
`ifdef BRCMP_STAT_EN
    ,
    .stat_clr    (stat_clr),
    .stat_issued (stat_issued),
    .stat_taken  (stat_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entry: {taken, eq, tag}
  logic [TAG_W+1:0] sb[$];
  logic             mv;          // modelled out_valid
  logic [31:0]      m_issued;
  logic [31:0]      m_taken;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference condition, computed on 64-bit sign-extended integers.
  function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sa < 0;
      3'd3: return sa >= 0;
      3'd4: return sa > 0;
      3'd5: return sa <= 0;
      3'd6: return sa < sb_;
      default: return ua < ub;
    endcase
  endfunction

  // One clock cycle: drive after the falling edge, check before the rising edge,
  // update the model across the edge.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] tag, input logic ordy, input logic fl, input logic sclr);
    logic exp_rdy, acc, cons, t;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
`ifdef BRCMP_STAT_EN
    stat_clr  = sclr;
`endif
    #1;
    exp_rdy = !mv || ordy;
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    check("out_valid", {63'd0, out_valid}, {63'd0, mv});
    if (mv && sb.size() > 0) begin
      check("out_taken", {63'd0, out_taken}, {63'd0, sb[0][TAG_W+1]});
      check("out_eq", {63'd0, out_eq}, {63'd0, sb[0][TAG_W]});
      check("out_tag", {60'd0, out_tag}, {60'd0, sb[0][TAG_W-1:0]});
    end
    acc  = v && exp_rdy && !fl;
    cons = mv && ordy;
    if (cons && sb.size() > 0) void'(sb.pop_front());
    if (fl) sb.delete();
    t = ref_taken(op, a, b);
    if (acc) sb.push_back({t, a == b, tag});
    if (sclr) begin
      m_issued = 0;
      m_taken  = 0;
    end else if (acc) begin
      if (m_issued != 32'hFFFF_FFFF) m_issued++;
      if (t && m_taken != 32'hFFFF_FFFF) m_taken++;
    end
    @(posedge clk);
    mv = fl ? 1'b0 : acc ? 1'b1 : cons ? 1'b0 : mv;
    @(negedge clk);
`ifdef BRCMP_STAT_EN
    check("stat_issued", {32'd0, stat_issued}, {32'd0, m_issued});
    check("stat_taken", {32'd0, stat_taken}, {32'd0, m_taken});
`endif
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, ordy, 1'b0, 1'b0);
  endtask

  logic [31:0] pool[8];

  initial begin
    pool[0] = 32'h8000_0000; pool[1] = 32'h7FFF_FFFF; pool[2] = 32'h0000_0000;
    pool[3] = 32'hFFFF_FFFF; pool[4] = 32'h0000_0001; pool[5] = 32'h1234_5678;
    pool[6] = 32'h8000_0001; pool[7] = 32'h0000_0001;
    mv = 1'b0; m_issued = 0; m_taken = 0;
    rst = 1'b1; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_tag = 0;
    flush = 0; out_ready = 0;
`ifdef BRCMP_STAT_EN
    stat_clr = 0;
`endif
    // Reset values with no clock edge yet.
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_taken", {63'd0, out_taken}, 64'd0);
    check("rst_out_eq", {63'd0, out_eq}, 64'd0);
    check("rst_out_tag", {60'd0, out_tag}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Mode sweep: 0,1,1,0,0,1,1,0 expected via the reference model.
    for (int op = 0; op < 8; op++)
      cyc(1'b1, op[2:0], 32'h8000_0000, 32'h7FFF_FFFF, op[3:0], 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // Zero / minus-one boundaries for the single-operand modes.
    for (int op = 0; op < 8; op++) begin
      cyc(1'b1, op[2:0], 32'd0, 32'd0, op[3:0], 1'b1, 1'b0, 1'b0);
      cyc(1'b1, op[2:0], 32'hFFFF_FFFF, 32'd1, op[3:0] + 4'd8, 1'b1, 1'b0, 1'b0);
    end
    idle(1'b1);

    // Backpressure: tag 3 held for 3 stalled cycles while another issue waits.
    cyc(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1, 4'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 3'd0, 32'd7, 32'd7, 4'd9, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 32'd7, 32'd7, 4'd4, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // Flush with a held result and a concurrent issue.
    cyc(1'b1, 3'd1, 32'd1, 32'd2, 4'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 32'd1, 32'd2, 4'd6, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // Streaming: 8 back-to-back EQ issues.
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 3'd0, pool[i], pool[(i + 1) % 8], i[3:0], 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // Random traffic with stalls and occasional flushes.
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pool[$urandom_range(0, 7)],
          pool[$urandom_range(0, 7)], 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 9) == 0), 1'b0);
    idle(1'b1);

    // Asynchronous reset mid-stream, between edges.
    cyc(1'b1, 3'd0, 32'd5, 32'd5, 4'd11, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_out_tag", {60'd0, out_tag}, 64'd0);
    check("arst_out_eq", {63'd0, out_eq}, 64'd0);
    sb.delete();
    mv = 1'b0; m_issued = 0; m_taken = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 3'd4, 32'd9, 32'd0, 4'd12, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // Stats pattern: 5 issues, 3 taken, then clear together with an issue.
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 3'd0, 32'd1, 32'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 32'd1, 32'd2, 4'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 32'h8000_0000, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 3'd7, 32'd3, 32'd2, 4'd4, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd0, 4'd5, 1'b1, 1'b0, 1'b0);
`ifdef BRCMP_STAT_EN
    check("stat_issued_5", {32'd0, stat_issued}, 64'd5);
    check("stat_taken_3", {32'd0, stat_taken}, 64'd3);
`endif
    cyc(1'b1, 3'd0, 32'd1, 32'd1, 4'd6, 1'b1, 1'b0, 1'b1);
`ifdef BRCMP_STAT_EN
    check("stat_issued_clr", {32'd0, stat_issued}, 64'd0);
    check("stat_taken_clr", {32'd0, stat_taken}, 64'd0);
`endif
    idle(1'b1);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_cmp_unit.md
BRANCH_CMP_UNIT -- requirements
Module: branch_cmp_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits, legal values 8 to 64.
REQ-002 Parameter TAG_W, default 4, width of the issue tag carried alongside each compare.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port in_valid, input, 1, issue request present.
REQ-006 Port in_ready, output, 1, unit can accept an issue this cycle.
REQ-007 Port in_op, input, 3, compare mode select.
REQ-008 Port in_a, input, WIDTH, first operand (rs).
REQ-009 Port in_b, input, WIDTH, second operand (rt); ignored by the single-operand modes.
REQ-010 Port in_tag, input, TAG_W, issue tag.
REQ-011 Port flush, input, 1, squash any result that is held in the unit or arriving in the same cycle.
REQ-012 Port out_valid, output, 1, result register holds a valid result.
REQ-013 Port out_ready, input, 1, consumer accepts the result this cycle.
REQ-014 Port out_taken, output, 1, branch condition result.
REQ-015 Port out_eq, output, 1, raw equality of the captured operands, independent of in_op.
REQ-016 Port out_tag, output, TAG_W, tag of the held result.

Function
REQ-017 in_op encoding: 000 EQ a==b; 001 NE a!=b; 010 LTZ a<0 signed; 011 GEZ a>=0 signed; 100 GTZ a>0 signed; 101 LEZ a<=0 signed; 110 LT a<b signed; 111 LTU a<b unsigned.
REQ-018 Signed modes treat bit WIDTH-1 as the sign bit; the comparison is WIDTH bits wide and has no overflow wrap (e.g. most-negative < most-positive is true).
REQ-019 Handshake: an issue is accepted when in_valid && in_ready && !flush.
REQ-020 Handshake: a result is consumed when out_valid && out_ready.
REQ-021 in_ready is combinational and equals !out_valid || out_ready; it does not depend on flush.
REQ-022 Latency is exactly one cycle: an issue accepted at edge N has out_valid, out_taken, out_eq and out_tag valid after edge N.
REQ-023 When an accept and a consume occur in the same cycle, the result register is reloaded and out_valid stays 1, giving one result per cycle throughput.
REQ-024 If out_valid=1 and out_ready=0, out_taken, out_eq and out_tag are held stable.
REQ-025 flush=1 at an edge clears out_valid and blocks acceptance that cycle, regardless of in_valid, out_ready or in_ready.
REQ-026 out_taken, out_eq and out_tag are don't-care while out_valid=0, but they only change on an accept.

Reset
REQ-027 While rst=1, out_valid=0, out_taken=0, out_eq=0 and out_tag=0, asynchronously and with no clock required.
REQ-028 On rst deassertion the unit is idle with in_ready=1; any result in flight when rst asserts is discarded.

Configuration
REQ-029 Macro BRCMP_STAT_EN defined: the unit adds input stat_clr (1 bit) and two 32-bit outputs, stat_issued and stat_taken.
REQ-030 With BRCMP_STAT_EN, stat_issued increments on each accept and stat_taken increments on each accept whose computed condition is true.
REQ-031 With BRCMP_STAT_EN, both counters saturate at 0xFFFFFFFF, are cleared by rst, and are cleared synchronously by stat_clr (stat_clr has priority over an increment).
REQ-032 Macro BRCMP_STAT_EN undefined: the stat ports and counter logic are absent, and all other behaviour is identical.

Verification
REQ-033 Mode sweep: WIDTH=32, a=0x80000000, b=0x7FFFFFFF through all eight ops -> out_taken = 0,1,1,0,0,1,1,0 in op order, each one cycle after issue.
REQ-034 Backpressure: issue tag 3 with out_ready=0 for 3 cycles -> in_ready=0 and the outputs are frozen; raising out_ready while issuing tag 4 in the same cycle -> tag 3 is consumed and tag 4 appears on the next edge.
REQ-035 Flush: flush with a held result and a concurrent in_valid -> out_valid=0 next cycle, no accept, and with stats on, stat_issued is unchanged.
REQ-036 Streaming: 8 back-to-back EQ issues with out_ready=1 -> 8 consecutive cycles of out_valid=1 with tags in issue order and no bubbles.
REQ-037 Reset: assert rst mid-stream asynchronously between edges -> out_valid falls immediately; after release in_ready=1 and the first issue completes in one cycle.
REQ-038 Stats (BRCMP_STAT_EN): 5 issues with 3 taken -> stat_issued=5 and stat_taken=3; stat_clr together with an issue -> both counters read 0.
